// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the set-2 scan-code to ASCII table
// used by the PS/2 keyboard decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] BREAK_CODE  = 8'hF0;
    localparam logic [7:0] EXT_CODE    = 8'hE0;
    localparam logic [7:0] LSHIFT_CODE = 8'h12;
    localparam logic [7:0] RSHIFT_CODE = 8'h59;

    function automatic logic [7:0] scan_to_ascii(
        input logic [7:0] code,
        input logic       shift
    );
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61;
            8'h32: a = 8'h62;
            8'h21: a = 8'h63;
            8'h23: a = 8'h64;
            8'h24: a = 8'h65;
            8'h2B: a = 8'h66;
            8'h34: a = 8'h67;
            8'h33: a = 8'h68;
            8'h43: a = 8'h69;
            8'h3B: a = 8'h6A;
            8'h42: a = 8'h6B;
            8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;
            8'h31: a = 8'h6E;
            8'h44: a = 8'h6F;
            8'h4D: a = 8'h70;
            8'h15: a = 8'h71;
            8'h2D: a = 8'h72;
            8'h1B: a = 8'h73;
            8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;
            8'h2A: a = 8'h76;
            8'h1D: a = 8'h77;
            8'h22: a = 8'h78;
            8'h35: a = 8'h79;
            8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;
            8'h16: a = 8'h31;
            8'h1E: a = 8'h32;
            8'h26: a = 8'h33;
            8'h25: a = 8'h34;
            8'h2E: a = 8'h35;
            8'h36: a = 8'h36;
            8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        // Only letters have a shifted form
        if (shift && a >= 8'h61 && a <= 8'h7A)
            a = a - 8'h20;
        return a;
    endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Show-ahead FIFO for decoded key events; overflowing pushes are dropped,
// empty pops are ignored.
module ps2_key_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       valid,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 keyboard receiver: synchronises the pad, frames bytes, tracks
// make/break/shift state and queues pressed keys as ASCII.
module ps2_ascii_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] press,
    output logic       key_valid,
    output logic [7:0] key_ascii,
    input  logic       key_rd,
    output logic       fifo_full,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    clk_sr;
    logic [1:0]    dat_sr;
    logic          fall;
    logic          bit_in;
    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo;
    logic          byte_valid;
    logic [7:0]    rx_byte;
    logic          brk;
    logic          ext;
    logic          lshift;
    logic          rshift;
    logic [7:0]    held;
    logic [7:0]    mapped;
    logic          is_prefix;
    logic          is_shift;
    logic          push;

    // clk_sr[1] is the synchronised pad clock, clk_sr[2] its previous value
    assign fall   = clk_sr[2] & ~clk_sr[1];
    assign bit_in = dat_sr[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr <= 3'b111;
            dat_sr <= 2'b11;
        end else begin
            clk_sr <= {clk_sr[1:0], ps2_clk};
            dat_sr <= {dat_sr[0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tmo        <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tmo <= '0;
                case (state)
                    IDLE: begin
                        if (!bit_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par   <= bit_in;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (bit_in && (^{shreg, par})) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo == TMO_MAX) begin
                    state <= IDLE;
                    tmo   <= '0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end else begin
                tmo <= '0;
            end
        end
    end

    always_comb begin
        mapped    = scan_to_ascii(rx_byte, lshift | rshift);
        is_prefix = (rx_byte == BREAK_CODE) || (rx_byte == EXT_CODE);
        is_shift  = (rx_byte == LSHIFT_CODE) || (rx_byte == RSHIFT_CODE);
        push      = byte_valid && !is_prefix && !ext && !brk && !is_shift
                    && (mapped != 8'h00) && (rx_byte != held);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press  <= 8'h00;
            held   <= 8'h00;
            brk    <= 1'b0;
            ext    <= 1'b0;
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == BREAK_CODE) begin
                brk <= 1'b1;
            end else if (rx_byte == EXT_CODE) begin
                ext <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
                if (!ext) begin
                    if (rx_byte == LSHIFT_CODE) begin
                        lshift <= !brk;
                    end else if (rx_byte == RSHIFT_CODE) begin
                        rshift <= !brk;
                    end else if (brk) begin
                        if (rx_byte == held) begin
                            press <= 8'h00;
                            held  <= 8'h00;
                        end
                    end else if (push) begin
                        press <= mapped;
                        held  <= rx_byte;
                    end
                end
            end
        end
    end

    ps2_key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .din  (mapped),
        .pop  (key_rd),
        .dout (key_ascii),
        .valid(key_valid),
        .full (fifo_full)
    );

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: serialises PS/2 frames and checks
// press, FIFO and error outputs against hand-computed values.
module tb_ps2_ascii_decoder;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] press;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       key_rd;
    logic       fifo_full;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    ps2_ascii_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .press    (press),
        .key_valid(key_valid),
        .key_ascii(key_ascii),
        .key_rd   (key_rd),
        .fifo_full(fifo_full),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk)
        if (frame_err === 1'b1)
            err_cnt++;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++)
            ps2_bit(code[i]);
        ps2_bit((~^code) ^ bad_par);
        ps2_bit(1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic pop();
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] codes [9];
    logic [7:0] asc   [9];

    initial begin
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                  8'h2B, 8'h34, 8'h33, 8'h43};
        asc   = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
                  8'h66, 8'h67, 8'h68, 8'h69};
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        key_rd   = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_press", press, 8'h00);
        check("rst_valid", key_valid, 8'h00);
        check("rst_ascii", key_ascii, 8'h00);
        check("rst_full", fifo_full, 8'h00);
        check("rst_err", frame_err, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain make, typematic repeat, pop, break
        send_frame(8'h1C, 1'b0);
        check("a_press", press, 8'h61);
        check("a_valid", key_valid, 8'h01);
        check("a_ascii", key_ascii, 8'h61);
        send_frame(8'h1C, 1'b0);
        pop();
        check("a_pop_valid", key_valid, 8'h00);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("a_break", press, 8'h00);

        // Shifted letter
        send_frame(8'h12, 1'b0);
        check("shift_press", press, 8'h00);
        send_frame(8'h1C, 1'b0);
        check("A_press", press, 8'h41);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("A_break", press, 8'h00);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        check("A_ascii", key_ascii, 8'h41);
        pop();
        check("A_single", key_valid, 8'h00);

        // Bad parity
        send_frame(8'h1C, 1'b1);
        check("par_err", err_cnt[7:0], 8'h01);
        check("par_press", press, 8'h00);
        check("par_valid", key_valid, 8'h00);

        // FIFO fill and overflow
        for (int i = 0; i < 9; i++) begin
            send_frame(codes[i], 1'b0);
            if (i == 6) check("full_at7", fifo_full, 8'h00);
            if (i == 7) check("full_at8", fifo_full, 8'h01);
        end
        check("full_at9", fifo_full, 8'h01);
        check("press_9", press, 8'h69);
        for (int i = 0; i < 8; i++) begin
            check("fifo_order", key_ascii, asc[i]);
            pop();
        end
        check("fifo_empty", key_valid, 8'h00);
        check("fifo_nfull", fifo_full, 8'h00);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h43, 1'b0);
        check("i_break", press, 8'h00);

        // Partial frame abandoned by timeout
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        repeat (50010) @(negedge clk);
        send_frame(8'h16, 1'b0);
        check("tmo_press", press, 8'h31);
        check("tmo_ascii", key_ascii, 8'h31);
        check("tmo_noerr", err_cnt[7:0], 8'h01);
        pop();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h16, 1'b0);
        check("one_break", press, 8'h00);

        // Extended code ignored
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("ext_press", press, 8'h00);
        check("ext_valid", key_valid, 8'h00);

        // Reset mid-frame
        send_frame(8'h1C, 1'b0);
        check("pre_rst_press", press, 8'h61);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_press", press, 8'h00);
        check("mid_rst_valid", key_valid, 8'h00);
        check("mid_rst_ascii", key_ascii, 8'h00);
        check("mid_rst_full", fifo_full, 8'h00);
        check("mid_rst_err", frame_err, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h29, 1'b0);
        check("post_rst_press", press, 8'h20);
        check("post_rst_ascii", key_ascii, 8'h20);
        check("post_rst_valid", key_valid, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
